ul_cfg_src: RTL
===============

// Module: ul_cfg_src
// PURPOSE
//  SoC-side config source that feeds ul_cfg_gen. Host writes config records
//  into a word buffer; each record is 1 address-header word followed by
//  NUM_WORDS data words. On each soc_req pulse the block streams one whole
//  record as a gap-free burst on soc_valid/soc_cfg_data, then idles low.
//  The consumer treats the header as the address and the data words as payload.
// PARAMETERS
//  NUM_WORDS  16  data words per record; header excluded; 16 = two 256b channels
//  BUF_DEPTH  64  word buffer depth; power of 2 and >= NUM_WORDS+1
//  GAP_CYC    1   minimum soc_valid-low cycles after a burst; range 1..15
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   reset, asynchronous, active-low
//  syn_rst       in   1   soft reset, synchronous, from CSR
//  host_wr_vld   in   1   host word valid
//  host_wr_data  in   32  host word; header first, then NUM_WORDS data words
//  host_wr_rdy   out  1   buffer not full; word accepted when vld&rdy
//  soc_req       in   1   1-cycle request pulse from ul_cfg_gen
//  soc_valid     out  1   burst word valid; registered
//  soc_cfg_data  out  32  burst word; registered
//  rec_cnt       out  $clog2(BUF_DEPTH/(NUM_WORDS+1)+1)  complete records buffered
//  burst_done    out  1   1-cycle pulse in the cycle after the last burst word
// BEHAVIOUR
//  Reset (rst_n low or syn_rst): soc_valid=0, soc_cfg_data=0, burst_done=0,
//   rec_cnt=0, host_wr_rdy=1. Buffer pointers, word index, req_pend and FSM
//   clear. syn_rst overrides every other event in the same cycle.
//  Write side:
//   - wr_idx counts 0..NUM_WORDS per accepted word and wraps to 0.
//   - rec_cnt +1 on the accept at wr_idx==NUM_WORDS.
//   - host_wr_rdy = (word count < BUF_DEPTH), combinational.
//   - Partial records are never streamed.
//  Request: soc_req sets req_pend; req_pend clears when a burst starts.
//   soc_req while req_pend is set, or during BURST/GAP, merges: one pending max.
//  FSM states IDLE, BURST, GAP:
//   IDLE->BURST when (req_pend|soc_req) & rec_cnt!=0.
//    - Edge t with soc_req high and rec_cnt>=1: soc_valid=1 with the header
//      from t+1.
//    - rec_cnt -1 at the start edge.
//   BURST: one word popped and presented per cycle, no stalls. Exactly
//    NUM_WORDS+1 consecutive soc_valid cycles: header, then data in write order.
//   BURST->GAP after the last word. soc_valid=0, soc_cfg_data=0,
//    burst_done=1 for one cycle.
//   GAP: hold GAP_CYC cycles, then go to IDLE. A pending request may start in
//    the IDLE cycle, so minimum spacing between bursts = GAP_CYC+1 low cycles.
//  A burst always drains fully. The record is consumed even if the consumer
//   rejects the header; the consumer re-requests the next record.
//  Simultaneous push and pop in the same cycle: word count unchanged; rec_cnt
//   +1 and -1 in the same cycle net to 0.
//  Pointers wrap modulo BUF_DEPTH. Word count is $clog2(BUF_DEPTH)+1 bits.
//  Record completion in the same cycle as a soc_req with rec_cnt==0: no start;
//   req_pend holds and the burst starts the next cycle.
//  SVA:
//   - soc_valid is never high for more than NUM_WORDS+1 cycles in a row.
//   - No pop when empty.
//   - No push when full.
// STRUCTURE
//  ul_cfg_pkg:
//   - UL_CFG_WORD_W=32
//   - UL_CFG_NUM_WORDS=16
//   - typedef enum logic[1:0] ul_src_state_e {IDLE,BURST,GAP}
//  One sub-module: pp_fifo (DEPTH=BUF_DEPTH, DATA_WIDTH=32), the existing
//   first-word-fall-through FIFO. clear_pointers=syn_rst.
//   data_out registers into soc_cfg_data on each pop.
//  Remaining logic in ul_cfg_src: FSM, burst counter, GAP counter, wr_idx,
//   rec_cnt, req_pend.
// TESTING
//  1 Reset, then idle 10 cycles -> soc_valid=0, soc_cfg_data=0,
//    host_wr_rdy=1, rec_cnt=0.
//  2 Write 0x0000_1000, 0x1..0x10; pulse soc_req at t ->
//    - soc_valid high t+1..t+17 with 0x1000,0x1..0x10
//    - burst_done at t+18
//    - rec_cnt 1->0 at t+1
//  3 soc_req with empty buffer, then write one record -> no soc_valid until the
//    17th word is accepted; burst starts the cycle after rec_cnt becomes 1.
//  4 Write 64 words, no requests -> host_wr_rdy=0 after the 64th word;
//    rec_cnt=3. One burst -> rdy returns to 1 after the first pop.
//  5 Two records; soc_req pulsed during burst 1 -> burst 2 starts after exactly
//    GAP_CYC+1 low cycles, data matches record 2.
//  6 syn_rst at word 5 of a burst -> next cycle: soc_valid=0, rec_cnt=0,
//    host_wr_rdy=1, no burst_done; a later soc_req produces no burst.

Source files
------------

// File: rtl/ul_cfg_pkg.sv
// Shared constants and types for the uplink config source and its consumers.
package ul_cfg_pkg;

    localparam int UL_CFG_WORD_W    = 32;
    localparam int UL_CFG_NUM_WORDS = 16;
    localparam int UL_CFG_BUF_DEPTH = 64;
    localparam int UL_CFG_GAP_CYC   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } ul_src_state_e;

    // Width of a counter able to hold every complete record the buffer can contain.
    function automatic int ul_rec_cnt_w(input int buf_depth, input int num_words);
        return $clog2(buf_depth / (num_words + 1) + 1);
    endfunction

endpackage

// File: rtl/pp_fifo.sv
// First-word-fall-through word FIFO: data_out always shows the oldest entry.
// Pointers wrap modulo DEPTH (power of 2); count is one bit wider than a pointer.
module pp_fifo #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_pointers,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [PTR_W:0]        count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  full;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign data_out = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_pointers) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/ul_cfg_src.sv
// SoC-side config source: buffers host-written records (header + NUM_WORDS data)
// and streams one complete record per soc_req as a gap-free registered burst.
module ul_cfg_src
    import ul_cfg_pkg::*;
#(
    parameter int NUM_WORDS  = UL_CFG_NUM_WORDS,
    parameter int BUF_DEPTH  = UL_CFG_BUF_DEPTH,
    parameter int GAP_CYC    = UL_CFG_GAP_CYC,
    localparam int REC_W     = ul_rec_cnt_w(BUF_DEPTH, NUM_WORDS),
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1,
    localparam int IDX_W     = $clog2(NUM_WORDS + 1),
    localparam int BCNT_W    = $clog2(NUM_WORDS + 2)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     syn_rst,
    input  logic                     host_wr_vld,
    input  logic [UL_CFG_WORD_W-1:0] host_wr_data,
    output logic                     host_wr_rdy,
    input  logic                     soc_req,
    output logic                     soc_valid,
    output logic [UL_CFG_WORD_W-1:0] soc_cfg_data,
    output logic [REC_W-1:0]         rec_cnt,
    output logic                     burst_done,
    output ul_src_state_e            dbg_state_o
);

    localparam int BURST_LEN = NUM_WORDS + 1;

    ul_src_state_e              state_q;
    logic [IDX_W-1:0]           wr_idx_q;
    logic [IDX_W-1:0]           wr_idx_d;
    logic [REC_W-1:0]           rec_cnt_q;
    logic [REC_W-1:0]           rec_cnt_d;
    logic                       req_pend_q;
    logic                       req_pend_d;
    logic [BCNT_W-1:0]          burst_cnt_q;
    logic [3:0]                 gap_cnt_q;
    logic                       soc_valid_q;
    logic [UL_CFG_WORD_W-1:0]   soc_data_q;
    logic                       burst_done_q;
    logic [BCNT_W:0]            valid_run_q;

    logic [CNT_W-1:0]           word_cnt;
    logic [UL_CFG_WORD_W-1:0]   fifo_dout;
    logic                       push;
    logic                       pop;
    logic                       start;
    logic                       burst_more;
    logic                       rec_done;

    assign host_wr_rdy = (word_cnt < CNT_W'(BUF_DEPTH));
    assign push        = host_wr_vld & host_wr_rdy & ~syn_rst;
    assign rec_done    = push & (wr_idx_q == IDX_W'(NUM_WORDS));
    // Only whole records are counted, so a start always has BURST_LEN words behind it.
    assign start       = (state_q == IDLE) & (req_pend_q | soc_req) & (rec_cnt_q != '0);
    assign burst_more  = (state_q == BURST) & (burst_cnt_q != BCNT_W'(BURST_LEN));
    assign pop         = (start | burst_more) & ~syn_rst;

    pp_fifo #(
        .DEPTH      (BUF_DEPTH),
        .DATA_WIDTH (UL_CFG_WORD_W)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_pointers (syn_rst),
        .push           (push),
        .data_in        (host_wr_data),
        .pop            (pop),
        .data_out       (fifo_dout),
        .count          (word_cnt)
    );

    always_comb begin
        wr_idx_d = wr_idx_q;
        if (push) begin
            wr_idx_d = (wr_idx_q == IDX_W'(NUM_WORDS)) ? '0 : wr_idx_q + 1'b1;
        end

        rec_cnt_d = rec_cnt_q;
        if (rec_done && !start) begin
            rec_cnt_d = rec_cnt_q + 1'b1;
        end else if (start && !rec_done) begin
            rec_cnt_d = rec_cnt_q - 1'b1;
        end

        // Requests arriving while one is already pending or a burst is in flight merge.
        req_pend_d = req_pend_q;
        if (start) begin
            req_pend_d = 1'b0;
        end else if (soc_req) begin
            req_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_idx_q     <= '0;
            rec_cnt_q    <= '0;
            req_pend_q   <= 1'b0;
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            soc_valid_q  <= 1'b0;
            soc_data_q   <= '0;
            burst_done_q <= 1'b0;
        end else if (syn_rst) begin
            state_q      <= IDLE;
            wr_idx_q     <= '0;
            rec_cnt_q    <= '0;
            req_pend_q   <= 1'b0;
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            soc_valid_q  <= 1'b0;
            soc_data_q   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            rec_cnt_q  <= rec_cnt_d;
            req_pend_q <= req_pend_d;
            case (state_q)
                IDLE: begin
                    burst_done_q <= 1'b0;
                    if (start) begin
                        state_q     <= BURST;
                        soc_valid_q <= 1'b1;
                        soc_data_q  <= fifo_dout;
                        burst_cnt_q <= BCNT_W'(1);
                    end
                end
                BURST: begin
                    if (burst_more) begin
                        soc_data_q  <= fifo_dout;
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end else begin
                        state_q      <= GAP;
                        soc_valid_q  <= 1'b0;
                        soc_data_q   <= '0;
                        burst_done_q <= 1'b1;
                        gap_cnt_q    <= '0;
                    end
                end
                GAP: begin
                    burst_done_q <= 1'b0;
                    if (gap_cnt_q == 4'(GAP_CYC - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Length of the soc_valid run up to the previous cycle, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_run_q <= '0;
        end else if (!soc_valid_q) begin
            valid_run_q <= '0;
        end else if (valid_run_q != '1) begin
            valid_run_q <= valid_run_q + 1'b1;
        end
    end

    burst_len_bound: assert property (@(posedge clk) disable iff (!rst_n)
        !(soc_valid_q && (valid_run_q >= (BCNT_W + 1)'(BURST_LEN))));

    assign soc_valid    = soc_valid_q;
    assign soc_cfg_data = soc_data_q;
    assign rec_cnt      = rec_cnt_q;
    assign burst_done   = burst_done_q;
    assign dbg_state_o  = state_q;

endmodule
